// File: rtl/poly_mul_sequencer.sv
// Sequences one polynomial-multiply job: latches operands, pulses the core clear,
// waits out the core latency, captures NUM_OUT coefficients and hands back a result.
module poly_mul_sequencer #(
    parameter int unsigned CORE_LAT = 3,
    parameter int unsigned NUM_OUT  = 4
) (
    input  logic        man_clk,
    input  logic        man_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [15:0] req_b,
    input  logic        abort,
    output logic        core_clr,
    output logic [7:0]  core_a,
    output logic [15:0] core_b,
    input  logic [1:0]  core_coeff,
    input  logic [3:0]  core_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_err,
    output logic        busy,
    output logic [7:0]  jobs_done
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        WAIT,
        CAPT,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(CORE_LAT);
    localparam logic [1:0] LAST_CAPT = 2'(NUM_OUT - 1);
    localparam logic [3:0] SLOT_MASK = 4'((32'd1 << NUM_OUT) - 32'd1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [1:0]  capt_cnt;
    logic [3:0]  seen;
    logic [3:0]  seen_next;
    logic [15:0] data_next;
    logic        slot_ok;
    logic        err_next;
    logic        deliver;

    assign req_ready = (state == IDLE);
    assign core_clr  = (state == CLR);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign deliver   = (state == DONE) && res_ready && !abort;

    always_ff @(posedge man_clk or posedge man_reset) begin
        if (man_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort overrides every transition out of a busy state, including delivery.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (req_valid) state_next = CLR;
            CLR:  state_next = WAIT;
            WAIT: if (wait_cnt == 4'd1) state_next = CAPT;
            CAPT: if (capt_cnt == LAST_CAPT) state_next = DONE;
            DONE: if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
        end
    end

    // The error flag must include the slot written on the final capture cycle.
    always_comb begin
        seen_next = seen;
        data_next = res_data;
        slot_ok   = (32'(core_coeff) < NUM_OUT);
        if ((state == CAPT) && slot_ok) begin
            seen_next[core_coeff]                 = 1'b1;
            data_next[{core_coeff, 2'b00} +: 4] = core_out;
        end
        err_next = ((seen_next & SLOT_MASK) != SLOT_MASK);
    end

    always_ff @(posedge man_clk or posedge man_reset) begin
        if (man_reset) begin
            core_a   <= '0;
            core_b   <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
            seen     <= '0;
            wait_cnt <= '0;
            capt_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        core_a   <= req_a;
                        core_b   <= req_b;
                        res_data <= '0;
                        res_err  <= 1'b0;
                        seen     <= '0;
                    end
                end
                CLR: begin
                    wait_cnt <= WAIT_LOAD;
                    capt_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                CAPT: begin
                    res_data <= data_next;
                    seen     <= seen_next;
                    capt_cnt <= capt_cnt + 2'd1;
                    if (capt_cnt == LAST_CAPT) begin
                        res_err <= err_next;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge man_clk or posedge man_reset) begin
        if (man_reset) begin
            jobs_done <= '0;
        end else if (deliver) begin
            jobs_done <= jobs_done + 8'd1;
        end
    end

endmodule
